aes_rr_arbiter: RTL and testbench

- Shares one aes_core (single-block AES-128 encryptor) between NUM_REQ requesters.
- Each requester presents a key/plaintext pair with valid/ready. The arbiter grants round-robin, sequences one encryption on the core, and returns the ciphertext with valid/ready.
- Sits between client logic (e.g. DMA or packet engines) and aes_top/aes_core.
- Only one block is in flight at a time.

---
 rtl/aes_arb_pkg.sv | 14 +
 rtl/aes_rr_arbiter_rr_pick.sv | 31 +++
 rtl/aes_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_aes_rr_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and widths for the round-robin AES core arbiter.
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;
    localparam int STAT_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/aes_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set request at or above ptr,
// wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any_valid,
    output logic [IDX_W-1:0]   grant
);

    logic [IDX_W:0] sum;

    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_valid && req[sum[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                grant     = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter sharing one single-block AES-128 core between NUM_REQ clients.
// Build option: define AES_ARB_STATS_EN to get a saturating completed-block counter.
//
// state    | meaning
// ST_IDLE  | pick next requester, accept and latch its key/plaintext
// ST_ISSUE | pulse core_start once the core is not busy
// ST_WAIT  | wait for core_done, capture ciphertext
// ST_RESP  | present ciphertext to the granted requester until rsp_ready
module aes_rr_arbiter
    import aes_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_plaintext,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [AES_BLK_W-1:0]         rsp_ciphertext,
    output logic                         core_start,
    output logic [AES_BLK_W-1:0]         core_key,
    output logic [AES_BLK_W-1:0]         core_plaintext,
    input  logic                         core_done,
    input  logic                         core_busy,
    input  logic [AES_BLK_W-1:0]         core_ciphertext,
    output logic [STAT_W-1:0]            stat_blocks
);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     pick;
    logic                 any_valid;
    logic [AES_BLK_W-1:0] key_q;
    logic [AES_BLK_W-1:0] pt_q;
    logic [AES_BLK_W-1:0] ct_q;
    logic [AES_BLK_W-1:0] sel_key;
    logic [AES_BLK_W-1:0] sel_pt;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [NUM_REQ-1:0]   grant_oh;
    logic                 rsp_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .any_valid (any_valid),
        .grant     (pick)
    );

    always_comb begin
        pick_oh  = '0;
        grant_oh = '0;
        sel_key  = '0;
        sel_pt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_oh[i] = 1'b1;
                sel_key    = req_key[AES_BLK_W*i +: AES_BLK_W];
                sel_pt     = req_plaintext[AES_BLK_W*i +: AES_BLK_W];
            end
            if (grant_q == IDX_W'(i)) begin
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Accept and start are combinational so a block costs no extra cycle;
    // gating with rst keeps both quiet while reset is held.
    assign req_ready      = (state == ST_IDLE && any_valid && !rst) ? pick_oh : '0;
    assign core_start     = (state == ST_ISSUE) && !core_busy && !rst;
    assign rsp_valid      = (state == ST_RESP) ? grant_oh : '0;
    assign rsp_hs         = (state == ST_RESP) && |(rsp_ready & grant_oh);
    assign rsp_ciphertext = ct_q;
    assign core_key       = key_q;
    assign core_plaintext = pt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            grant_q <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        key_q   <= sel_key;
                        pt_q    <= sel_pt;
                        grant_q <= pick;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!core_busy) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        ct_q  <= core_ciphertext;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        ptr   <= (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + IDX_W'(1);
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AES_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (rsp_hs && stat_q != '1) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign stat_blocks = stat_q;
`else
    assign stat_blocks = '0;
`endif

endmodule

// File: tb/tb_aes_rr_arbiter.sv
// Bench for aes_rr_arbiter: behavioural AES-128 core model, per-requester
// drivers and a scoreboard of expected ciphertexts keyed on accept order.
module tb_aes_rr_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [127:0] k;
        logic [127:0] p;
    } blk_t;

    typedef struct {
        int           idx;
        logic [127:0] ct;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*128-1:0] req_key;
    logic [N*128-1:0] req_plaintext;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [127:0]     rsp_ciphertext;
    logic             core_start;
    logic [127:0]     core_key;
    logic [127:0]     core_plaintext;
    logic             core_done;
    logic             core_busy;
    logic [127:0]     core_ct;
    logic [31:0]      stat_blocks;

    logic mock_busy, mock_done, force_busy, spur_done;
    assign core_busy = mock_busy | force_busy;
    assign core_done = mock_done | spur_done;

    aes_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_key         (req_key),
        .req_plaintext   (req_plaintext),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_ciphertext  (rsp_ciphertext),
        .core_start      (core_start),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .core_busy       (core_busy),
        .core_ciphertext (core_ct),
        .stat_blocks     (stat_blocks)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    initial begin
        logic [7:0] inv, x8;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, x8);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- core model: fixed 3-cycle latency ----------------
    initial begin
        logic         st;
        logic [127:0] mk, mp;
        int           mcnt;
        mock_busy = 1'b0;
        mock_done = 1'b0;
        core_ct   = '0;
        mcnt      = 0;
        mk        = '0;
        mp        = '0;
        forever begin
            @(negedge clk);
            st = core_start;
            if (st) begin
                mk = core_key;
                mp = core_plaintext;
            end
            @(posedge clk);
            #1;
            mock_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mock_done = 1'b1;
                    mock_busy = 1'b0;
                    core_ct   = aes_enc(mk, mp);
                end
            end
            if (st) begin
                mock_busy = 1'b1;
                mcnt      = 3;
            end
        end
    end

    // ---------------- requester drivers, monitor and scoreboard ----------------
    blk_t         pend [N][$];
    exp_t         sb [$];
    int           glog [$];
    logic [127:0] last_ct [N];
    logic [127:0] acc_key, acc_pt;
    int           rsp_cnt = 0;
    int           blocks_since_rst = 0;
    int           start_cnt = 0;
    int           rdy_cycles = 0;

    task automatic push(input int i, input logic [127:0] k, input logic [127:0] p);
        blk_t b;
        b.k = k;
        b.p = p;
        pend[i].push_back(b);
    endtask

    initial begin
        logic [N-1:0] acc, hs;
        exp_t         e;
        req_valid     = '0;
        req_key       = '0;
        req_plaintext = '0;
        acc_key       = '0;
        acc_pt        = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            hs  = rsp_valid & rsp_ready;
            if (req_ready != '0) rdy_cycles++;
            if (core_start) begin
                start_cnt++;
                check("core_key", core_key, acc_key);
                check("core_plaintext", core_plaintext, acc_pt);
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    glog.push_back(i);
                    acc_key = req_key[128*i +: 128];
                    acc_pt  = req_plaintext[128*i +: 128];
                    e.idx   = i;
                    e.ct    = aes_enc(acc_key, acc_pt);
                    sb.push_back(e);
                end
            end
            if (hs != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 128'(hs), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("rsp_idx", 128'(hs), 128'(N'(1) << e.idx));
                    check("rsp_ct", rsp_ciphertext, e.ct);
                    last_ct[e.idx] = rsp_ciphertext;
                end
                rsp_cnt++;
                blocks_since_rst++;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) void'(pend[i].pop_front());
                if (pend[i].size() > 0) begin
                    req_valid[i]              = 1'b1;
                    req_key[128*i +: 128]       = pend[i][0].k;
                    req_plaintext[128*i +: 128] = pend[i][0].p;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic wait_rsp(input int target);
        int k;
        k = 0;
        while (rsp_cnt < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rsp_wait", 128'(rsp_cnt >= target), 128'(1));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_stat();
`ifdef AES_ARB_STATS_EN
        return 32'(blocks_since_rst);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int           base, r0, s0, g0, k;
        int           exp_order [5];
        logic [127:0] hold_ct;
        rst        = 1'b1;
        rsp_ready  = '1;
        force_busy = 1'b0;
        spur_done  = 1'b0;
        exp_order  = '{0, 1, 2, 3, 0};
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_rsp_ct", rsp_ciphertext, 128'(0));
        check("rst_core_key", core_key, 128'(0));
        check("rst_stat", 128'(stat_blocks), 128'(0));

        // single request, FIPS-197 C.1 vector
        tick(1);
        r0 = rdy_cycles;
        push(0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        wait_rsp(1);
        check("single_ct", last_ct[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("single_ready_cycles", 128'(rdy_cycles - r0), 128'(1));

        // spurious core_done while idle
        tick(2);
        base = rsp_cnt;
        s0   = start_cnt;
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        repeat (5) @(negedge clk);
        check("spur_done_rsp", 128'(rsp_cnt), 128'(base));
        check("spur_done_start", 128'(start_cnt), 128'(s0));

        // lone request from 3 is granted even though the pointer sits at 1
        tick(1);
        push(3, rnd128(), rnd128());
        wait_rsp(base + 1);
        check("lone_grant", 128'(glog[glog.size()-1]), 128'(3));

        // contention: pointer now 0, all four valid plus a second block from req0
        tick(1);
        base = rsp_cnt;
        g0   = glog.size();
        push(0, rnd128(), rnd128());
        push(0, rnd128(), rnd128());
        push(1, rnd128(), rnd128());
        push(2, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
        push(3, rnd128(), rnd128());
        wait_rsp(base + 5);
        for (int j = 0; j < 5; j++) check($sformatf("grant_order_%0d", j), 128'(glog[g0+j]), 128'(exp_order[j]));
        check("fips_ct", last_ct[2], 128'h3925841d02dc09fbdc118597196a0b32);

        // backpressure on requester 1
        tick(1);
        base = rsp_cnt;
        rsp_ready[1] = 1'b0;
        push(1, rnd128(), rnd128());
        k = 0;
        while (rsp_valid[1] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", 128'(rsp_valid), 128'(4'b0010));
        hold_ct = rsp_ciphertext;
        tick(1);
        push(2, rnd128(), rnd128());
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 128'(rsp_valid), 128'(4'b0010));
            check("bp_hold_ct", rsp_ciphertext, hold_ct);
            check("bp_no_accept", 128'(req_ready), 128'(0));
        end
        tick(1);
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_hs_cycle_no_accept", 128'(req_ready), 128'(0));
        @(negedge clk);
        check("bp_done_valid", 128'(rsp_valid), 128'(0));
        check("bp_done_cnt", 128'(rsp_cnt), 128'(base + 1));
        wait_rsp(base + 2);

        // core busy on entry to ISSUE
        tick(1);
        base = rsp_cnt;
        g0   = glog.size();
        force_busy = 1'b1;
        push(3, rnd128(), rnd128());
        k = 0;
        while (glog.size() == g0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        s0 = start_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("busy_no_start", 128'(core_start), 128'(0));
        end
        tick(1);
        force_busy = 1'b0;
        wait_rsp(base + 1);
        check("busy_one_start", 128'(start_cnt - s0), 128'(1));

        // reset while the core is working
        tick(1);
        base = rsp_cnt;
        push(0, rnd128(), rnd128());
        k = 0;
        while (mock_busy !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        blocks_since_rst = 0;
        @(negedge clk);
        check("midrst_req_ready", 128'(req_ready), 128'(0));
        check("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("midrst_core_start", 128'(core_start), 128'(0));
        check("midrst_rsp_ct", rsp_ciphertext, 128'(0));
        check("midrst_core_key", core_key, 128'(0));
        check("midrst_stat", 128'(stat_blocks), 128'(0));
        repeat (10) @(negedge clk);
        check("late_done_no_rsp", 128'(rsp_cnt), 128'(base));
        tick(1);
        push(1, rnd128(), rnd128());
        wait_rsp(base + 1);

        // ten blocks since reset
        tick(1);
        for (int j = 0; j < 9; j++) push($urandom_range(N-1), rnd128(), rnd128());
        wait_rsp(base + 10);
        repeat (2) @(negedge clk);
        check("stat_blocks", 128'(stat_blocks), 128'(exp_stat()));
        check("sb_drained", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
